// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per step over req/ack, hands it to decode over valid/ready.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter logic [15:0] PC_STEP        = 16'd1,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_take,
    input  logic [15:0] branch_target,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_err
);

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        START,
        REQ,
        HOLD,
        HALTED
    } state_t;

    state_t state;

    // The wait counter is 4 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be in 1..15");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_W-1:0] wait_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    // The address bus is the PC register itself, so it can never disagree with pc during a request.
    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= START;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                START: begin
                    state   <= REQ;
                    mem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                REQ: begin
                    if (mem_ack) begin
                        instr       <= mem_rdata;
                        instr_valid <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // An ack on the limit cycle is taken above and wins over the timeout.
                    else if (wait_cnt == WAIT_LIMIT) begin
                        fetch_err <= 1'b1;
                        mem_req   <= 1'b0;
                        halted    <= 1'b1;
                        state     <= HALTED;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= branch_take ? branch_target : pc + PC_STEP;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            mem_req <= 1'b1;
                            state   <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, branches, wrap, halt, reset abort and timeout.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_ready;
    logic        branch_take;
    logic [15:0] branch_target;
    logic        halt;

    logic [15:0] pc, mem_addr, instr;
    logic        mem_req, instr_valid, halted, fetch_err;
    logic [15:0] pc2, mem_addr2, instr2;
    logic        mem_req2, instr_valid2, halted2, fetch_err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .branch_take(branch_take), .branch_target(branch_target),
        .halt(halt), .halted(halted), .fetch_err(fetch_err)
    );

    // Second instance starting at the top of the address space to exercise PC wrap.
    fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .reset(reset), .pc(pc2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready), .branch_take(branch_take), .branch_target(branch_target),
        .halt(halt), .halted(halted2), .fetch_err(fetch_err2)
    );

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000; instr_ready = 1'b0;
        branch_take = 1'b0; branch_target = 16'h0000; halt = 1'b0;
        step(); step();

        // Reset state of both instances
        chk16("rst_pc", pc, 16'h0000);
        chk1("rst_req", mem_req, 1'b0);
        chk16("rst_instr", instr, 16'h0000);
        chk1("rst_valid", instr_valid, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_err", fetch_err, 1'b0);
        chk16("rst_pc2", pc2, 16'hFFFF);
        chk16("rst_addr2", mem_addr2, 16'hFFFF);
        chk1("rst_req2", mem_req2, 1'b0);
        chk1("rst_valid2", instr_valid2, 1'b0);
        chk16("rst_instr2", instr2, 16'h0000);
        chk1("rst_halted2", halted2, 1'b0);
        chk1("rst_err2", fetch_err2, 1'b0);

        // Back-to-back fetch: ack immediately, decode always ready
        reset = 1'b0; mem_ack = 1'b1; instr_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("seq_req", mem_req, 1'b1);
            chk16("seq_addr", mem_addr, 16'(i));
            chk1("seq_valid_lo", instr_valid, 1'b0);
            mem_rdata = 16'hA000 + 16'(i);
            step();
            chk1("seq_valid_hi", instr_valid, 1'b1);
            chk16("seq_instr", instr, 16'hA000 + 16'(i));
            chk1("seq_req_lo", mem_req, 1'b0);
            if (i == 0) chk16("wrap_before", mem_addr2, 16'hFFFF);
            step();
            if (i == 0) chk16("wrap_after", mem_addr2, 16'h0000);
        end

        // Delayed ack (3 request cycles) then decode stalls 4 cycles
        mem_ack = 1'b0; instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk1("slow_req", mem_req, 1'b1);
            chk16("slow_addr", mem_addr, 16'h0004);
            if (c == 2) begin
                mem_ack = 1'b1; mem_rdata = 16'hB004;
            end
            step();
        end
        mem_rdata = 16'hC0DE;
        for (int c = 0; c < 4; c++) begin
            chk1("stall_valid", instr_valid, 1'b1);
            chk16("stall_instr", instr, 16'hB004);
            chk1("stall_req", mem_req, 1'b0);
            step();
        end
        chk16("stall_instr_end", instr, 16'hB004);
        mem_ack = 1'b0; instr_ready = 1'b1;
        step();
        chk16("after_stall_addr", mem_addr, 16'h0005);

        // Branch pulses outside the handshake must not redirect
        branch_take = 1'b1; branch_target = 16'h0777; instr_ready = 1'b0;
        step();
        chk16("br_req_ignored", mem_addr, 16'h0005);
        branch_take = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hA005;
        step();
        mem_ack = 1'b0; branch_take = 1'b1;
        step();
        chk1("br_hold_valid", instr_valid, 1'b1);
        chk16("br_hold_ignored", mem_addr, 16'h0005);
        branch_take = 1'b0; instr_ready = 1'b1;
        step();
        chk16("br_seq_addr", mem_addr, 16'h0006);

        // Branch chain: 6 -> 0x0010 -> 0x0100 -> 0x0005
        mem_ack = 1'b1; step();
        mem_ack = 1'b0; branch_take = 1'b1; branch_target = 16'h0010; step();
        chk16("br_to_10", mem_addr, 16'h0010);
        mem_ack = 1'b1; branch_take = 1'b0; step();
        mem_ack = 1'b0; branch_take = 1'b1; branch_target = 16'h0100; step();
        chk16("br_to_100", mem_addr, 16'h0100);
        chk1("br_to_100_req", mem_req, 1'b1);
        mem_ack = 1'b1; branch_take = 1'b0; step();
        mem_ack = 1'b0; branch_take = 1'b1; branch_target = 16'h0005; step();
        chk16("br_to_5", mem_addr, 16'h0005);

        // Halt on handshake at pc=5
        mem_ack = 1'b1; branch_take = 1'b0; step();
        mem_ack = 1'b0; halt = 1'b1; step();
        halt = 1'b0;
        chk16("halt_pc", pc, 16'h0006);
        chk1("halt_halted", halted, 1'b1);
        chk1("halt_valid", instr_valid, 1'b0);
        for (int c = 0; c < 20; c++) begin
            mem_ack = (c % 2 == 0);
            chk1("halt_req", mem_req, 1'b0);
            step();
        end
        chk16("halt_pc_frozen", pc, 16'h0006);
        chk1("halt_still", halted, 1'b1);

        // Reset out of HALTED, then abort a request mid-flight
        reset = 1'b1; mem_ack = 1'b0; step();
        chk1("rst2_halted", halted, 1'b0);
        chk16("rst2_pc", pc, 16'h0000);
        reset = 1'b0; step();
        chk1("abort_req", mem_req, 1'b1);
        step();
        reset = 1'b1; step();
        chk1("abort_req_lo", mem_req, 1'b0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hEEEE; step();
        chk1("abort_valid", instr_valid, 1'b0);
        chk1("abort_rereq", mem_req, 1'b1);
        chk16("abort_addr", mem_addr, 16'h0000);
        mem_ack = 1'b0; step();
        chk1("abort_valid2", instr_valid, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'hD000; step();
        chk1("restart_valid", instr_valid, 1'b1);
        chk16("restart_instr", instr, 16'hD000);

        // Branch and halt together: branch target loads, then halt
        mem_ack = 1'b0; branch_take = 1'b1; halt = 1'b1; branch_target = 16'h0200;
        instr_ready = 1'b1; step();
        branch_take = 1'b0; halt = 1'b0;
        chk16("brhalt_pc", pc, 16'h0200);
        chk1("brhalt_halted", halted, 1'b1);
        chk1("brhalt_req", mem_req, 1'b0);

        // Memory never acks
        reset = 1'b1; instr_ready = 1'b0; step();
        reset = 1'b0; step();
        for (int c = 1; c < 8; c++) begin
            step();
            chk1("noack_req", mem_req, 1'b1);
            chk1("noack_err", fetch_err, 1'b0);
        end
        step();
`ifdef FETCH_TIMEOUT_EN
        chk1("to_err", fetch_err, 1'b1);
        chk1("to_halted", halted, 1'b1);
        chk1("to_req", mem_req, 1'b0);
        chk16("to_pc", pc, 16'h0000);
`else
        chk1("wait_err", fetch_err, 1'b0);
        chk1("wait_halted", halted, 1'b0);
        chk1("wait_req", mem_req, 1'b1);
        chk16("wait_addr", mem_addr, 16'h0000);
`endif

        // Ack arrives on the last permitted request cycle
        reset = 1'b1; step();
        reset = 1'b0; step();
        repeat (7) step();
        chk1("limit_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 16'hF00D; step();
        chk1("limit_err", fetch_err, 1'b0);
        chk1("limit_valid", instr_valid, 1'b1);
        chk16("limit_instr", instr, 16'hF00D);
        chk1("limit_halted", halted, 1'b0);
        mem_ack = 1'b0; instr_ready = 1'b1; step();
        chk16("limit_next_addr", mem_addr, 16'h0001);
        chk1("limit_next_req", mem_req, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
